// File: rtl/memio_access_ctrl.sv
// Data-memory / MMIO sequencer: arbitrates CPU and loader onto the single-port data BRAM,
// decodes IO space and owns the LED, 7-seg and sticky button-flag registers.
module memio_access_ctrl #(
  parameter int unsigned MEM_AW      = 14,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic [MEM_AW-1:0] ldr_addr,
  input  logic [31:0]       ldr_wdata,
  output logic              ldr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic [15:0]       sw_in,
  input  logic              btn_a,
  input  logic              btn_b,
  input  logic              btn_mode,
  output logic [15:0]       led_out,
  output logic [31:0]       seg_value,
  output logic [7:0]        seg_en
);

  typedef enum logic [2:0] {StIdle, StWr, StRdIssue, StRdWait, StIoRd, StAck} state_e;

  state_e            state_q;
  logic              owner_cpu_q;
  logic              last_cpu_q;
  logic              io_q;
  logic [9:0]        io_off_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q, sync_m_q;
  logic              prev_a_q, prev_b_q;
  logic              flag_a_q, flag_b_q;

  logic              cpu_is_io;
  logic              grant_ldr, grant_cpu;
  logic              rise_a, rise_b, clr_a, clr_b;
  logic              mode_sync;
  logic [31:0]       io_rdata;

  assign cpu_rdata = rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

  always_comb begin
    cpu_is_io = &cpu_addr[31:10];
    // On a tie the requester not served last time wins.
    grant_ldr = ldr_req & (~cpu_req | last_cpu_q);
    grant_cpu = cpu_req & ~grant_ldr;
  end

  always_comb begin
    mode_sync = sync_m_q[SYNC_STAGES-1];
    rise_a    = sync_a_q[SYNC_STAGES-1] & ~prev_a_q;
    rise_b    = sync_b_q[SYNC_STAGES-1] & ~prev_b_q;
    clr_a     = (state_q == StIoRd) && (io_off_q == 10'h074);
    clr_b     = (state_q == StIoRd) && (io_off_q == 10'h078);
  end

  always_comb begin
    io_rdata = 32'h0;
    case (io_off_q)
      10'h070: io_rdata = {16'h0, sw_in};
      10'h074: io_rdata = {31'h0, flag_a_q};
      10'h078: io_rdata = {31'h0, flag_b_q};
      10'h088: io_rdata = {31'h0, mode_sync};
      default: io_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      sync_m_q <= '0;
      prev_a_q <= 1'b0;
      prev_b_q <= 1'b0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], btn_a};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], btn_b};
      sync_m_q <= {sync_m_q[SYNC_STAGES-2:0], btn_mode};
      prev_a_q <= sync_a_q[SYNC_STAGES-1];
      prev_b_q <= sync_b_q[SYNC_STAGES-1];
    end
  end

  // A new edge in the clearing cycle takes priority so no press is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_a_q <= 1'b0;
      flag_b_q <= 1'b0;
    end else begin
      if (rise_a)     flag_a_q <= 1'b1;
      else if (clr_a) flag_a_q <= 1'b0;
      if (rise_b)     flag_b_q <= 1'b1;
      else if (clr_b) flag_b_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_cpu_q <= 1'b0;
      last_cpu_q  <= 1'b1;
      io_q        <= 1'b0;
      io_off_q    <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cpu_ack     <= 1'b0;
      ldr_ack     <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      led_out     <= '0;
      seg_value   <= '0;
      seg_en      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_ldr) begin
            owner_cpu_q <= 1'b0;
            last_cpu_q  <= 1'b0;
            io_q        <= 1'b0;
            mem_en      <= 1'b1;
            mem_we      <= 1'b1;
            mem_addr    <= ldr_addr;
            mem_wdata   <= ldr_wdata;
            state_q     <= StWr;
          end else if (grant_cpu) begin
            owner_cpu_q <= 1'b1;
            last_cpu_q  <= 1'b1;
            io_q        <= cpu_is_io;
            io_off_q    <= cpu_addr[9:0];
            wdata_q     <= cpu_wdata;
            if (cpu_we) begin
              state_q <= StWr;
              if (!cpu_is_io) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= cpu_addr[MEM_AW+1:2];
                mem_wdata <= cpu_wdata;
              end
            end else if (cpu_is_io) begin
              state_q <= StIoRd;
            end else begin
              mem_en   <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= cpu_addr[MEM_AW+1:2];
              state_q  <= StRdIssue;
            end
          end
        end
        StWr: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (io_q) begin
            case (io_off_q)
              10'h07C: led_out   <= wdata_q[15:0];
              10'h080: seg_value <= wdata_q;
              10'h084: seg_en    <= wdata_q[7:0];
              default: ;
            endcase
          end
          cpu_ack <= owner_cpu_q;
          ldr_ack <= ~owner_cpu_q;
          state_q <= StAck;
        end
        StRdIssue: begin
          mem_en  <= 1'b0;
          state_q <= StRdWait;
        end
        StRdWait: begin
          rdata_q <= mem_rdata;
          cpu_ack <= 1'b1;
          state_q <= StAck;
        end
        StIoRd: begin
          rdata_q <= io_rdata;
          cpu_ack <= 1'b1;
          state_q <= StAck;
        end
        StAck: begin
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_memio_access_ctrl.sv
// Scoreboard bench for memio_access_ctrl: drivers push expected acks, a monitor checks them.
module tb_memio_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        ldr_req;
  logic [13:0] ldr_addr;
  logic [31:0] ldr_wdata;
  logic        ldr_ack;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [15:0] sw_in;
  logic        btn_a, btn_b, btn_mode;
  logic [15:0] led_out;
  logic [31:0] seg_value;
  logic [7:0]  seg_en;

  memio_access_ctrl #(.MEM_AW(14), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .sw_in(sw_in), .btn_a(btn_a), .btn_b(btn_b), .btn_mode(btn_mode),
    .led_out(led_out), .seg_value(seg_value), .seg_en(seg_en)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int en_cnt = 0;
  int wr_cnt = 0;
  logic [13:0] last_wr_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Data BRAM stub: synchronous read, one cycle latency.
  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    if (mem_en) begin
      en_cnt <= en_cnt + 1;
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wr_cnt        <= wr_cnt + 1;
        last_wr_addr  <= mem_addr;
      end
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        is_cpu;
    logic        chk_data;
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;

  always @(negedge clk) begin
    if (cpu_ack || ldr_ack) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: cpu_ack=%0d ldr_ack=%0d cyc=%0d, required no ack",
                 cpu_ack, ldr_ack, cyc);
      end else begin
        m_e = sb.pop_front();
        if (cpu_ack !== m_e.is_cpu || ldr_ack !== !m_e.is_cpu || cyc != m_e.cyc ||
            (m_e.chk_data && cpu_rdata !== m_e.data)) begin
          bad++;
          $display("FAIL %s: got cpu_ack=%0d ldr_ack=%0d cyc=%0d rdata=%h, required cpu=%0d cyc=%0d rdata=%h",
                   m_e.name, cpu_ack, ldr_ack, cyc, cpu_rdata, m_e.is_cpu, m_e.cyc, m_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_cpu, input logic chk_data, input logic [31:0] data,
                          input int at, input string name);
    exp_t e;
    e.is_cpu = is_cpu; e.chk_data = chk_data; e.data = data; e.cyc = at; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_cpu_ack(input logic check_stall, input string name);
    logic got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (check_stall) chk({name, "_stall"}, 32'(cpu_stall), cpu_ack ? 32'd0 : 32'd1);
      if (cpu_ack) begin
        got = 1'b1;
        cpu_req = 1'b0;
        break;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no cpu_ack, required ack within 20 cycles", name);
      cpu_req = 1'b0;
    end
  endtask

  // Starts one CPU access with the DUT idle; lat is the ack cycle relative to cycle 0.
  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input int lat, input logic check_stall,
                        input string name);
    @(posedge clk); #1;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    push_exp(1'b1, !we, exp_rdata, cyc + lat, name);
    wait_cpu_ack(check_stall, name);
  endtask

  int saved_en;
  int c0;
  int acks;

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_addr = '0; ldr_wdata = '0; sw_in = '0;
    btn_a = 1'b0; btn_b = 1'b0; btn_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_ldr_ack", 32'(ldr_ack), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);
    chk("rst_seg_value", seg_value, 32'd0);
    chk("rst_seg_en", 32'(seg_en), 32'd0);
    rst_n = 1'b1;

    // Memory store then load.
    cpu_op(1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 2, 1'b0, "sw_mem");
    chk("sw_mem_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("sw_mem_addr", 32'(last_wr_addr), 32'd4);
    chk("sw_mem_data", mem[4], 32'h1234_5678);
    cpu_op(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 3, 1'b1, "lw_mem");

    // IO registers; BRAM must stay idle.
    saved_en = en_cnt;
    sw_in = 16'h00F0;
    cpu_op(1'b1, 32'hFFFF_FC7C, 32'h0000_A5A5, 32'h0, 2, 1'b0, "sw_led");
    chk("led_out", 32'(led_out), 32'h0000_A5A5);
    chk("rdata_held", cpu_rdata, 32'h1234_5678);
    cpu_op(1'b0, 32'hFFFF_FC70, 32'h0, 32'h0000_00F0, 2, 1'b0, "lw_sw_in");
    cpu_op(1'b1, 32'hFFFF_FC80, 32'hDEAD_BEEF, 32'h0, 2, 1'b0, "sw_seg_value");
    cpu_op(1'b1, 32'hFFFF_FC84, 32'h0000_01FF, 32'h0, 2, 1'b0, "sw_seg_en");
    chk("seg_value", seg_value, 32'hDEAD_BEEF);
    chk("seg_en", 32'(seg_en), 32'h0000_00FF);

    // Sticky button flags.
    @(posedge clk); #1; btn_a = 1'b1;
    repeat (3) @(posedge clk);
    #1; btn_a = 1'b0;
    repeat (4) @(posedge clk);
    cpu_op(1'b0, 32'hFFFF_FC74, 32'h0, 32'h1, 2, 1'b0, "flag_a_set");
    cpu_op(1'b0, 32'hFFFF_FC74, 32'h0, 32'h0, 2, 1'b0, "flag_a_clr");
    // Edge lands in the IO_RD cycle of the clearing read, so the flag survives.
    @(posedge clk); #1; btn_a = 1'b1;
    cpu_op(1'b0, 32'hFFFF_FC74, 32'h0, 32'h0, 2, 1'b0, "flag_a_race_rd");
    btn_a = 1'b0;
    cpu_op(1'b0, 32'hFFFF_FC74, 32'h0, 32'h1, 2, 1'b0, "flag_a_race_kept");
    @(posedge clk); #1; btn_b = 1'b1;
    repeat (4) @(posedge clk);
    #1; btn_b = 1'b0;
    cpu_op(1'b0, 32'hFFFF_FC78, 32'h0, 32'h1, 2, 1'b0, "flag_b_set");

    // Unmapped IO.
    cpu_op(1'b0, 32'hFFFF_FC90, 32'h0, 32'h0, 2, 1'b0, "lw_unmapped");
    cpu_op(1'b1, 32'hFFFF_FC90, 32'hFFFF_FFFF, 32'h0, 2, 1'b0, "sw_unmapped");
    chk("unmapped_led", 32'(led_out), 32'h0000_A5A5);
    chk("unmapped_seg_value", seg_value, 32'hDEAD_BEEF);
    chk("unmapped_seg_en", 32'(seg_en), 32'h0000_00FF);

    // Mode is a plain synchronized level.
    btn_mode = 1'b1;
    repeat (3) @(posedge clk);
    cpu_op(1'b0, 32'hFFFF_FC88, 32'h0, 32'h1, 2, 1'b0, "lw_mode");
    chk("io_no_mem_en", 32'(en_cnt), 32'(saved_en));

    // Reset in RD_WAIT aborts the read without an ack; held request restarts.
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 32'h0000_0010; cpu_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_cpu_rdata", cpu_rdata, 32'd0);
    chk("abort_led", 32'(led_out), 32'd0);
    chk("abort_seg_value", seg_value, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    push_exp(1'b1, 1'b1, 32'h1234_5678, cyc + 3, "lw_after_reset");
    wait_cpu_ack(1'b0, "lw_after_reset");

    // Both requesters held from reset: loader, CPU, loader, CPU.
    @(posedge clk); #1;
    rst_n = 1'b0;
    cpu_we = 1'b0; cpu_addr = 32'h0000_0014; cpu_req = 1'b1;
    ldr_addr = 14'd5; ldr_wdata = 32'hCAFE_0001; ldr_req = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    c0 = cyc;
    push_exp(1'b0, 1'b0, 32'h0, c0 + 2, "arb_ldr0");
    push_exp(1'b1, 1'b1, 32'hCAFE_0001, c0 + 6, "arb_cpu0");
    push_exp(1'b0, 1'b0, 32'h0, c0 + 9, "arb_ldr1");
    push_exp(1'b1, 1'b1, 32'hCAFE_0001, c0 + 13, "arb_cpu1");
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clk);
      if (cpu_ack || ldr_ack) acks++;
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    if (acks < 4) begin
      total++; bad++;
      $display("FAIL arb_timeout: got %0d acks, required 4", acks);
    end

    repeat (5) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
